// File: rtl/stream_upsizer.sv
// Packs RATIO narrow beats into one wide word behind a single-entry output register.
// Define STREAM_UPSIZER_LAST_EN to let last_i close a word early and report it on last_o.
module stream_upsizer #(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clr_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [DATA_WIDTH-1:0]       data_i,
  input  logic                        last_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [DATA_WIDTH*RATIO-1:0] data_o,
  output logic [RATIO-1:0]            strb_o,
  output logic                        last_o
);

  localparam int CNT_W = $clog2(RATIO);

  typedef enum logic {FILL, FULL} state_t;

  state_t                      state;
  logic [CNT_W-1:0]            cnt;
  logic [DATA_WIDTH*RATIO-1:0] data_q;
  logic [RATIO-1:0]            strb_q;
  logic                        last_q;
  logic                        last_eff;
  logic                        accept;
  logic                        closes;

`ifdef STREAM_UPSIZER_LAST_EN
  assign last_eff = last_i;
`else
  logic unused_last;
  assign unused_last = last_i;
  assign last_eff    = 1'b0;
`endif

  // A held word only frees its slot when downstream takes it, so upstream sees ready_i then.
  assign ready_o = rst_ni && !clr_i && ((state == FILL) || ready_i);
  assign accept  = valid_i && ready_o;
  assign closes  = accept && ((cnt == CNT_W'(RATIO - 1)) || last_eff);

  // The later lane write deliberately overrides the handshake clear, so a beat arriving
  // with the output handshake lands in lane 0 of an otherwise empty word.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      state  <= FILL;
      cnt    <= '0;
      data_q <= '0;
      strb_q <= '0;
      last_q <= 1'b0;
    end else begin
      if (state == FULL && ready_i) begin
        state  <= FILL;
        data_q <= '0;
        strb_q <= '0;
        last_q <= 1'b0;
      end
      if (accept) begin
        data_q[cnt*DATA_WIDTH +: DATA_WIDTH] <= data_i;
        strb_q[cnt]                          <= 1'b1;
        if (closes) begin
          state  <= FULL;
          cnt    <= '0;
          last_q <= last_eff;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign valid_o = (state == FULL);
  assign data_o  = data_q;
  assign strb_o  = strb_q;
  assign last_o  = last_q;

endmodule

// File: tb/tb_stream_upsizer.sv
// Self-checking bench for stream_upsizer: directed table, corner sequences, random traffic
// against a queue-based reference model.
module tb_stream_upsizer;

  localparam int DW = 8;
  localparam int R  = 4;
  localparam int W  = DW * R;
`ifdef STREAM_UPSIZER_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_ni;
  logic          clr_i;
  logic          valid_i;
  logic          ready_o;
  logic [DW-1:0] data_i;
  logic          last_i;
  logic          valid_o;
  logic          ready_i;
  logic [W-1:0]  data_o;
  logic [R-1:0]  strb_o;
  logic          last_o;

  stream_upsizer #(.DATA_WIDTH(DW), .RATIO(R)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .clr_i  (clr_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_i (data_i),
    .last_i (last_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .data_o (data_o),
    .strb_o (strb_o),
    .last_o (last_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a held word plus a queue of beats collected for the next word.
  logic          m_valid = 1'b0;
  logic [W-1:0]  m_data  = '0;
  logic [R-1:0]  m_strb  = '0;
  logic          m_last  = 1'b0;
  logic [DW-1:0] part[$];
  logic [W-1:0]  seen[$];

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          l;
    logic          r;
    logic          exp_valid;
    logic [W-1:0]  exp_data;
    logic [R-1:0]  exp_strb;
    logic          exp_last;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check against the model, then advance model and clock.
  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic l,
                               input logic r, input logic c, input logic rn);
    logic exp_ready;
    logic acc;
    valid_i = v; data_i = d; last_i = l; ready_i = r; clr_i = c; rst_ni = rn;
    #1;
    exp_ready = rn && !c && (!m_valid || r);
    checkOutput("ready_o", {63'd0, ready_o}, {63'd0, exp_ready});
    checkOutput("valid_o", {63'd0, valid_o}, {63'd0, m_valid});
    if (m_valid) begin
      checkOutput("data_o", {32'd0, data_o}, {32'd0, m_data});
      checkOutput("strb_o", {60'd0, strb_o}, {60'd0, m_strb});
      checkOutput("last_o", {63'd0, last_o}, {63'd0, m_last});
    end
    if (valid_o && ready_i && rn && !c) seen.push_back(data_o);
    @(posedge clk);
    if (!rn || c) begin
      m_valid = 1'b0;
      part.delete();
    end else begin
      acc = v && exp_ready;
      if (m_valid && r) m_valid = 1'b0;
      if (acc) begin
        part.push_back(d);
        if (part.size() == R || (LAST_EN && l)) begin
          m_valid = 1'b1;
          m_data  = '0;
          m_strb  = '0;
          for (int i = 0; i < part.size(); i++) begin
            m_data[i*DW +: DW] = part[i];
            m_strb[i]          = 1'b1;
          end
          m_last = LAST_EN && l;
          part.delete();
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic checkZero(input string name);
    checkOutput({name, " valid_o"}, {63'd0, valid_o}, 64'd0);
    checkOutput({name, " data_o"},  {32'd0, data_o},  64'd0);
    checkOutput({name, " strb_o"},  {60'd0, strb_o},  64'd0);
    checkOutput({name, " last_o"},  {63'd0, last_o},  64'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 32'h0000_0011, 4'h1, 1'b0};
    vecs[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 32'h0000_2211, 4'h3, 1'b0};
    vecs[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 32'h0033_2211, 4'h7, 1'b0};
    vecs[3] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 32'h4433_2211, 4'hF, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 4'h0, 1'b0};

    rst_ni = 1'b0; clr_i = 1'b0; valid_i = 1'b0; data_i = '0; last_i = 1'b0; ready_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkZero("reset");
    checkOutput("reset ready_o", {63'd0, ready_o}, 64'd0);

    // Four back-to-back beats, then the word drains and lanes read zero again.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].r, 1'b0, 1'b1);
      checkOutput($sformatf("vec%0d valid_o", i), {63'd0, valid_o}, {63'd0, vecs[i].exp_valid});
      checkOutput($sformatf("vec%0d data_o", i),  {32'd0, data_o},  {32'd0, vecs[i].exp_data});
      checkOutput($sformatf("vec%0d strb_o", i),  {60'd0, strb_o},  {60'd0, vecs[i].exp_strb});
      checkOutput($sformatf("vec%0d last_o", i),  {63'd0, last_o},  {63'd0, vecs[i].exp_last});
    end

    // Continuous traffic: 12 beats give three words with no bubble.
    seen.delete();
    for (int i = 1; i <= 12; i++) applyStimulus(1'b1, DW'(i), 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("stream words", seen.size(), 3);
    if (seen.size() == 3) begin
      checkOutput("stream w0", {32'd0, seen[0]}, 64'h0403_0201);
      checkOutput("stream w1", {32'd0, seen[1]}, 64'h0807_0605);
      checkOutput("stream w2", {32'd0, seen[2]}, 64'h0C0B_0A09);
    end

    // Held word under backpressure, then consumed.
    seen.delete();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'hB0 + DW'(i), 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (5) applyStimulus(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("stall data_o", {32'd0, data_o}, 64'hB3B2_B1B0);
    checkOutput("stall strb_o", {60'd0, strb_o}, 64'hF);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("stall words", seen.size(), 1);
    if (seen.size() == 1) checkOutput("stall w0", {32'd0, seen[0]}, 64'hB3B2_B1B0);

    // Clear drops a partial word and wins over the beat offered alongside it.
    seen.delete();
    repeat (2) applyStimulus(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h88, 1'b0, 1'b1, 1'b1, 1'b1);
    checkZero("clear");
    repeat (4) applyStimulus(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("clear words", seen.size(), 1);
    if (seen.size() == 1) checkOutput("clear w0", {32'd0, seen[0]}, 64'h5555_5555);

    // Reset mid-word drops the partial word.
    seen.delete();
    repeat (3) applyStimulus(1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0);
      checkZero("midreset");
    end
    repeat (4) applyStimulus(1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("reset words", seen.size(), 1);
    if (seen.size() == 1) checkOutput("reset w0", {32'd0, seen[0]}, 64'h6666_6666);

`ifdef STREAM_UPSIZER_LAST_EN
    applyStimulus(1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'hA2, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("early valid_o", {63'd0, valid_o}, 64'd1);
    checkOutput("early data_o",  {32'd0, data_o},  64'h0000_A2A1);
    checkOutput("early strb_o",  {60'd0, strb_o},  64'h3);
    checkOutput("early last_o",  {63'd0, last_o},  64'd1);
`else
    applyStimulus(1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'hA2, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("nolast valid_o", {63'd0, valid_o}, 64'd0);
    applyStimulus(1'b1, 8'hA3, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'hA4, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("nolast valid_o2", {63'd0, valid_o}, 64'd1);
    checkOutput("nolast data_o",   {32'd0, data_o},  64'hA4A3_A2A1);
    checkOutput("nolast strb_o",   {60'd0, strb_o},  64'hF);
    checkOutput("nolast last_o",   {63'd0, last_o},  64'd0);
`endif
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Random traffic with backpressure, early closes, clears and resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 5) == 0,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
                    $urandom_range(0, 59) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
